// File: rtl/fft_pkg.sv
// fft_pkg: types and constants shared by the FFT front-end blocks.
//   loader_state_e : sample loader FSM states
//   ERR_*          : bit positions inside the loader error code
//   MAX_LOG2_DEF   : default log2 of the largest supported frame
package fft_pkg;

    localparam int unsigned MAX_LOG2_DEF = 10;
    localparam int unsigned MIN_LOG2     = 3;
    localparam int unsigned LOG2_W       = 4;
    localparam int unsigned FCNT_W       = 16;

    localparam int unsigned ERR_W        = 3;
    localparam int unsigned ERR_SHORT    = 0;
    localparam int unsigned ERR_LONG     = 1;
    localparam int unsigned ERR_CFG      = 2;

    typedef enum logic [1:0] {
        LD_IDLE      = 2'd0,
        LD_FILL      = 2'd1,
        LD_WAIT_BANK = 2'd2
    } loader_state_e;

    // True when a requested frame length lies in [MIN_LOG2, max_log2].
    function automatic logic cfg_len_valid(input logic [LOG2_W-1:0] len,
                                           input int unsigned       max_log2);
        return (32'(len) >= MIN_LOG2) && (32'(len) <= max_log2);
    endfunction

endpackage

// File: rtl/fft_bitrev.sv
// fft_bitrev: combinational bit reversal over a run-time selectable length.
//   i_val   : index to reverse; bits at or above i_len are ignored
//   i_len   : number of low bits taking part in the reversal
//   o_rev_c : reversed index, bits at or above i_len forced to zero
module fft_bitrev
    import fft_pkg::*;
#(
    parameter int unsigned W = MAX_LOG2_DEF
) (
    input  logic [W-1:0]      i_val,
    input  logic [LOG2_W-1:0] i_len,
    output logic [W-1:0]      o_rev_c
);

    logic [W-1:0] w_masked;
    logic [W-1:0] w_rev_full;

    // Reverse all W bits, then shift down so the reversal spans i_len bits.
    always_comb begin
        w_masked   = '0;
        w_rev_full = '0;
        o_rev_c    = '0;
        for (int i = 0; i < int'(W); i++) begin
            w_masked[i] = (i < int'(i_len)) ? i_val[i] : 1'b0;
        end
        for (int i = 0; i < int'(W); i++) begin
            w_rev_full[i] = w_masked[int'(W) - 1 - i];
        end
        if (int'(i_len) <= int'(W)) begin
            o_rev_c = w_rev_full >> (int'(W) - int'(i_len));
        end
    end

endmodule

// File: rtl/fft_sample_loader.sv
// fft_sample_loader: streams complex samples into a ping-pong sample RAM.
//   clk_i, reset_n_i           : clock, asynchronous active-low reset
//   s_valid_i/s_ready_o/s_data_i/s_last_i : sample stream {imag,real}
//   enable_i, cfg_log2_len_i, cfg_bitrev_i : run control, latched in IDLE
//   mem_we_o/mem_bank_o/mem_addr_o/mem_wdata_o : RAM write port
//   frame_ready_o/frame_bank_o : one-cycle pulse per completed frame
//   bank_release_i/release_bank_i : consumer hands a bank back
//   err_o/err_code_o/err_clr_i : sticky {cfg,long,short} errors
//   frame_cnt_o                : completed frame counter
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [2*DATA_W-1:0] s_data_i,
    input  logic                s_last_i,
    input  logic                enable_i,
    input  logic [LOG2_W-1:0]   cfg_log2_len_i,
    input  logic                cfg_bitrev_i,
    output logic                mem_we_o,
    output logic                mem_bank_o,
    output logic [MAX_LOG2-1:0] mem_addr_o,
    output logic [2*DATA_W-1:0] mem_wdata_o,
    output logic                frame_ready_o,
    output logic                frame_bank_o,
    input  logic                bank_release_i,
    input  logic                release_bank_i,
    output logic                err_o,
    output logic [ERR_W-1:0]    err_code_o,
    input  logic                err_clr_i,
    output logic [FCNT_W-1:0]   frame_cnt_o
);

    loader_state_e       r_state;
    logic [LOG2_W-1:0]   r_len;
    logic                r_bitrev;
    logic [MAX_LOG2-1:0] r_count;
    logic                r_fill_bank;
    logic [1:0]          r_full;
    logic                r_frame_pend;
    logic                r_pend_bank;

    logic [MAX_LOG2-1:0] w_last_idx;
    logic                w_accept;
    logic                w_at_end;
    logic                w_complete;
    logic                w_short;
    logic [1:0]          w_full_rel;
    logic [1:0]          w_full_nxt;
    logic                w_fill_nxt;
    logic [MAX_LOG2-1:0] w_count_nxt;
    logic [MAX_LOG2-1:0] w_rev;
    logic [MAX_LOG2-1:0] w_addr;
    logic                w_cfg_ok;
    logic [ERR_W-1:0]    w_err_new;
    logic [ERR_W-1:0]    w_err_nxt;

    fft_bitrev #(
        .W (MAX_LOG2)
    ) u_bitrev (
        .i_val   (r_count),
        .i_len   (r_len),
        .o_rev_c (w_rev)
    );

    // Handshake, frame bookkeeping and bank occupancy for the coming edge.
    always_comb begin
        w_last_idx = MAX_LOG2'((32'd1 << r_len) - 32'd1);
        w_accept   = (r_state == LD_FILL) && s_valid_i && s_ready_o;
        w_at_end   = (r_count == w_last_idx);
        w_complete = w_accept && w_at_end;
        w_short    = w_accept && s_last_i && !w_at_end;

        // A release is applied before a completion in the same cycle.
        w_full_rel = r_full;
        if (bank_release_i) begin
            w_full_rel[release_bank_i] = 1'b0;
        end
        w_full_nxt = w_full_rel;
        if (w_complete) begin
            w_full_nxt[r_fill_bank] = 1'b1;
        end
        w_fill_nxt = r_fill_bank ^ w_complete;

        if (w_complete || w_short) begin
            w_count_nxt = '0;
        end else if (w_accept) begin
            w_count_nxt = r_count + MAX_LOG2'(1);
        end else begin
            w_count_nxt = r_count;
        end

        w_addr   = r_bitrev ? w_rev : r_count;
        w_cfg_ok = cfg_len_valid(cfg_log2_len_i, MAX_LOG2);

        // New errors override a clear issued in the same cycle.
        w_err_new            = '0;
        w_err_new[ERR_SHORT] = w_short;
        w_err_new[ERR_LONG]  = w_complete && !s_last_i;
        w_err_new[ERR_CFG]   = (r_state == LD_IDLE) && enable_i && !w_cfg_ok;
        w_err_nxt            = (err_clr_i ? '0 : err_code_o) | w_err_new;
    end

    // Loader FSM with registered stream, RAM and status outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= LD_IDLE;
            r_len         <= '0;
            r_bitrev      <= 1'b0;
            r_count       <= '0;
            r_fill_bank   <= 1'b0;
            r_full        <= '0;
            r_frame_pend  <= 1'b0;
            r_pend_bank   <= 1'b0;
            s_ready_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_bank_o    <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            frame_ready_o <= 1'b0;
            frame_bank_o  <= 1'b0;
            err_o         <= 1'b0;
            err_code_o    <= '0;
            frame_cnt_o   <= '0;
        end else begin
            // Write stage: one cycle behind the handshake.
            mem_we_o <= w_accept;
            if (w_accept) begin
                mem_bank_o  <= r_fill_bank;
                mem_addr_o  <= w_addr;
                mem_wdata_o <= s_data_i;
            end

            // Frame pulse trails the last write by one cycle.
            r_frame_pend <= w_complete;
            if (w_complete) begin
                r_pend_bank <= r_fill_bank;
            end
            frame_ready_o <= r_frame_pend;
            if (r_frame_pend) begin
                frame_bank_o <= r_pend_bank;
                frame_cnt_o  <= frame_cnt_o + FCNT_W'(1);
            end

            err_code_o  <= w_err_nxt;
            err_o       <= |w_err_nxt;
            r_full      <= w_full_nxt;
            r_fill_bank <= w_fill_nxt;
            r_count     <= w_count_nxt;

            case (r_state)
                LD_IDLE: begin
                    s_ready_o <= 1'b0;
                    if (enable_i && w_cfg_ok) begin
                        r_len     <= cfg_log2_len_i;
                        r_bitrev  <= cfg_bitrev_i;
                        r_count   <= '0;
                        r_state   <= LD_FILL;
                        s_ready_o <= !w_full_nxt[r_fill_bank];
                    end
                end
                LD_FILL: begin
                    if (!enable_i && (r_count == '0) && !w_accept) begin
                        // Stop only between frames.
                        r_state   <= LD_IDLE;
                        s_ready_o <= 1'b0;
                    end else if (w_complete && w_full_nxt[w_fill_nxt]) begin
                        r_state   <= LD_WAIT_BANK;
                        s_ready_o <= 1'b0;
                    end else begin
                        // Withhold ready at a boundary once enable has dropped.
                        s_ready_o <= !w_full_nxt[w_fill_nxt] &&
                                     (enable_i || (w_count_nxt != '0));
                    end
                end
                LD_WAIT_BANK: begin
                    s_ready_o <= 1'b0;
                    if (!enable_i) begin
                        r_state <= LD_IDLE;
                    end else if (!w_full_rel[r_fill_bank]) begin
                        r_state   <= LD_FILL;
                        s_ready_o <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= LD_IDLE;
                    s_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader: self-checking bench for fft_sample_loader.
`timescale 1ns/1ps
module tb_fft_sample_loader;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MAX_LOG2 = 10;

    logic                clk_i          = 1'b0;
    logic                reset_n_i      = 1'b1;
    logic                s_valid_i      = 1'b0;
    logic                s_ready_o;
    logic [2*DATA_W-1:0] s_data_i       = '0;
    logic                s_last_i       = 1'b0;
    logic                enable_i       = 1'b0;
    logic [3:0]          cfg_log2_len_i = '0;
    logic                cfg_bitrev_i   = 1'b0;
    logic                mem_we_o;
    logic                mem_bank_o;
    logic [MAX_LOG2-1:0] mem_addr_o;
    logic [2*DATA_W-1:0] mem_wdata_o;
    logic                frame_ready_o;
    logic                frame_bank_o;
    logic                bank_release_i = 1'b0;
    logic                release_bank_i = 1'b0;
    logic                err_o;
    logic [2:0]          err_code_o;
    logic                err_clr_i      = 1'b0;
    logic [15:0]         frame_cnt_o;

    always #5 clk_i = ~clk_i;

    fft_sample_loader #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .enable_i(enable_i), .cfg_log2_len_i(cfg_log2_len_i), .cfg_bitrev_i(cfg_bitrev_i),
        .mem_we_o(mem_we_o), .mem_bank_o(mem_bank_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .frame_ready_o(frame_ready_o), .frame_bank_o(frame_bank_o),
        .bank_release_i(bank_release_i), .release_bank_i(release_bank_i),
        .err_o(err_o), .err_code_o(err_code_o), .err_clr_i(err_clr_i), .frame_cnt_o(frame_cnt_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int bank; int addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { int bank; int cnt; int cyc; } fr_t;
    wr_t obs_wr[$];
    wr_t exp_wr[$];
    fr_t obs_fr[$];
    fr_t exp_fr[$];

    // Reference model: frame/bank bookkeeping expressed with plain arithmetic.
    int m_bank, m_count, m_len, m_bitrev, m_frames;
    int m_full[2];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Observe RAM writes and frame pulses just after each active edge.
    always @(posedge clk_i) begin
        #1;
        if (reset_n_i) begin
            if (mem_we_o) obs_wr.push_back('{int'(mem_bank_o), int'(mem_addr_o), mem_wdata_o, cyc});
            if (frame_ready_o) obs_fr.push_back('{int'(frame_bank_o), int'(frame_cnt_o), cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    function automatic int rev_bits(input int v, input int n);
        int r = 0;
        for (int i = 0; i < n; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic model_reset();
        m_bank = 0; m_count = 0; m_frames = 0; m_len = 3; m_bitrev = 0;
        m_full[0] = 0; m_full[1] = 0;
        obs_wr.delete(); exp_wr.delete(); obs_fr.delete(); exp_fr.delete();
    endtask

    task automatic model_accept(input logic [31:0] d, input logic last, input int hs_cyc);
        int n;
        n = 1 << m_len;
        exp_wr.push_back('{m_bank, (m_bitrev != 0) ? rev_bits(m_count, m_len) : m_count, d, hs_cyc});
        if (m_count == n - 1) begin
            m_frames = (m_frames + 1) % 65536;
            exp_fr.push_back('{m_bank, m_frames, hs_cyc + 1});
            m_full[m_bank] = 1;
            m_bank = 1 - m_bank;
            m_count = 0;
        end else if (last) begin
            m_count = 0;
        end else begin
            m_count++;
        end
    endtask

    task automatic idle(input int n);
        s_valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    // Offer one sample from a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [31:0] d, input logic last);
        bit done = 0;
        s_valid_i = 1'b1; s_data_i = d; s_last_i = last;
        for (int t = 0; t < 2000 && !done; t++) begin
            if (s_ready_o) begin
                done = 1;
                model_accept(d, last, cyc + 1);
            end
            @(negedge clk_i);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no ready required handshake");
        end
        s_valid_i = 1'b0; s_last_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        #1;
        chk("rst_ctl", {s_ready_o, mem_we_o, mem_bank_o, frame_ready_o, frame_bank_o,
                        err_o, err_code_o, frame_cnt_o}, 64'd0);
        chk("rst_data", {mem_addr_o, mem_wdata_o}, 64'd0);
        s_valid_i = 0; s_last_i = 0; s_data_i = '0; enable_i = 0; cfg_log2_len_i = '0;
        cfg_bitrev_i = 0; bank_release_i = 0; release_bank_i = 0; err_clr_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic start_cfg(input int len, input int br);
        cfg_log2_len_i = 4'(len); cfg_bitrev_i = 1'(br); enable_i = 1'b1;
        m_len = len; m_bitrev = br; m_count = 0;
    endtask

    task automatic check_streams(input string tag);
        int n;
        chk($sformatf("%s_nwr", tag), 64'(obs_wr.size()), 64'(exp_wr.size()));
        n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_wr%0d", tag, k),
                {1'(obs_wr[k].bank), 10'(obs_wr[k].addr), obs_wr[k].data},
                {1'(exp_wr[k].bank), 10'(exp_wr[k].addr), exp_wr[k].data});
            chk($sformatf("%s_wrcyc%0d", tag, k), 64'(obs_wr[k].cyc), 64'(exp_wr[k].cyc));
        end
        chk($sformatf("%s_nfr", tag), 64'(obs_fr.size()), 64'(exp_fr.size()));
        n = (obs_fr.size() < exp_fr.size()) ? obs_fr.size() : exp_fr.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_fr%0d", tag, k),
                {1'(obs_fr[k].bank), 16'(obs_fr[k].cnt), 32'(obs_fr[k].cyc)},
                {1'(exp_fr[k].bank), 16'(exp_fr[k].cnt), 32'(exp_fr[k].cyc)});
        end
        obs_wr.delete(); exp_wr.delete(); obs_fr.delete(); exp_fr.delete();
    endtask

    typedef struct {
        int         len;
        int         br;
        int         nsamp;
        int         last_at;
        logic [2:0] exp_err;
        int         exp_frames;
        int         exp_bank;
    } vec_t;

    initial begin
        vec_t vt[5];
        int   exp029[8];
        int   bad[2];
        int   hits[1024];
        int   cover_ok;

        vt[0] = '{3, 1,  8,  7, 3'b000, 1, 0};
        vt[1] = '{3, 0,  8,  7, 3'b000, 1, 0};
        vt[2] = '{4, 0,  6,  5, 3'b001, 0, 0};
        vt[3] = '{3, 0,  8, -1, 3'b010, 1, 0};
        vt[4] = '{5, 1, 32, 31, 3'b000, 1, 0};
        exp029 = '{0, 4, 2, 6, 1, 5, 3, 7};
        bad    = '{2, 11};

        @(negedge clk_i);

        // Single-frame vectors from a clean reset.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            start_cfg(vt[i].len, vt[i].br);
            for (int s = 0; s < vt[i].nsamp; s++) begin
                send((i == 0) ? 32'(s) : $urandom, s == vt[i].last_at);
            end
            idle(4);
            chk($sformatf("v%0d_err", i), err_code_o, vt[i].exp_err);
            chk($sformatf("v%0d_err_o", i), err_o, |vt[i].exp_err);
            chk($sformatf("v%0d_fcnt", i), frame_cnt_o, 64'(vt[i].exp_frames));
            chk($sformatf("v%0d_fbank", i), frame_bank_o, 64'(vt[i].exp_bank));
            if (i == 0 && obs_wr.size() >= 8) begin
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("bitrev8_addr%0d", k), {1'(obs_wr[k].bank), 10'(obs_wr[k].addr)},
                        {1'b0, 10'(exp029[k])});
                end
            end
            check_streams($sformatf("v%0d", i));
        end

        // Two frames without release stall; release reopens; release+completion together.
        do_reset();
        start_cfg(3, 0);
        for (int s = 0; s < 16; s++) send($urandom, (s % 8) == 7);
        idle(3);
        chk("wait_bank_ready", s_ready_o, 0);
        chk("wait_bank_fcnt", frame_cnt_o, 2);
        chk("wait_bank_fbank", frame_bank_o, 1);
        bank_release_i = 1'b1; release_bank_i = 1'b0;
        @(negedge clk_i);
        bank_release_i = 1'b0;
        m_full[0] = 0;
        chk("release_ready", s_ready_o, 1);
        for (int s = 0; s < 7; s++) send($urandom, 1'b0);
        bank_release_i = 1'b1; release_bank_i = 1'b1; m_full[1] = 0;
        send($urandom, 1'b1);
        bank_release_i = 1'b0;
        chk("rel_and_done_ready", s_ready_o, 1);
        idle(3);
        chk("rel_and_done_ready2", s_ready_o, 1);
        check_streams("pingpong");

        // Short frame is discarded, next full frame still lands in bank 0.
        do_reset();
        start_cfg(4, 0);
        for (int s = 0; s < 6; s++) send($urandom, s == 5);
        for (int s = 0; s < 16; s++) send($urandom, s == 15);
        idle(4);
        chk("short_err", err_code_o, 3'b001);
        chk("short_fcnt", frame_cnt_o, 1);
        chk("short_fbank", frame_bank_o, 0);
        check_streams("short");
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("short_clr", {err_o, err_code_o}, 0);

        // Out-of-range lengths are refused; clear loses against a fresh error.
        for (int b = 0; b < 2; b++) begin
            do_reset();
            cfg_log2_len_i = 4'(bad[b]); enable_i = 1'b1;
            repeat (3) @(negedge clk_i);
            chk($sformatf("cfg%0d_err", bad[b]), {err_o, err_code_o}, 4'b1100);
            chk($sformatf("cfg%0d_ready", bad[b]), s_ready_o, 0);
            err_clr_i = 1'b1;
            @(negedge clk_i);
            chk($sformatf("cfg%0d_clr_vs_new", bad[b]), err_code_o, 3'b100);
            enable_i = 1'b0;
            @(negedge clk_i);
            err_clr_i = 1'b0;
            chk($sformatf("cfg%0d_cleared", bad[b]), {err_o, err_code_o}, 0);
            chk($sformatf("cfg%0d_ready2", bad[b]), s_ready_o, 0);
        end

        // Reset mid-frame drops the partial frame.
        do_reset();
        start_cfg(3, 0);
        for (int s = 0; s < 5; s++) send(32'h100 + 32'(s), 1'b0);
        check_streams("mid_pre");
        do_reset();
        start_cfg(3, 0);
        for (int s = 0; s < 8; s++) send(32'h200 + 32'(s), s == 7);
        idle(4);
        if (obs_wr.size() > 0) chk("post_rst_first", {1'(obs_wr[0].bank), 10'(obs_wr[0].addr)}, 0);
        chk("post_rst_fcnt", frame_cnt_o, 1);
        chk("post_rst_fbank", frame_bank_o, 0);
        check_streams("post_rst");
        enable_i = 1'b0;
        idle(3);
        chk("disable_ready", s_ready_o, 0);
        enable_i = 1'b1;
        idle(2);
        chk("reenable_ready", s_ready_o, 1);

        // Full 1024-point frame with random gaps.
        do_reset();
        start_cfg(10, int'($urandom_range(0, 1)));
        for (int s = 0; s < 1024; s++) begin
            idle(int'($urandom_range(0, 3)));
            send($urandom, s == 1023);
        end
        idle(4);
        for (int a = 0; a < 1024; a++) hits[a] = 0;
        foreach (obs_wr[k]) hits[obs_wr[k].addr & 1023]++;
        cover_ok = 1;
        for (int a = 0; a < 1024; a++) if (hits[a] != 1) cover_ok = 0;
        chk("big_cover", 64'(cover_ok), 1);
        chk("big_nwr", 64'(obs_wr.size()), 1024);
        chk("big_nfr", 64'(obs_fr.size()), 1);
        chk("big_err", err_code_o, 0);
        check_streams("big");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each real/imag component.
REQ-002 SHALL have parameter MAX_LOG2, default 10, log2 of largest supported frame (1024 points).
REQ-003 SHALL have ports: clk_i  in  1  single clock; reset_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: s_valid_i in 1, s_ready_o out 1, s_data_i in 2*DATA_W {imag,real}, s_last_i in 1 (final sample of frame).
REQ-005 SHALL have ports: enable_i in 1 run; cfg_log2_len_i in 4 frame log2 length; cfg_bitrev_i in 1 bit-reversed write order.
REQ-006 SHALL have ports: mem_we_o out 1, mem_bank_o out 1, mem_addr_o out MAX_LOG2, mem_wdata_o out 2*DATA_W (ping-pong sample RAM write port).
REQ-007 SHALL have ports: frame_ready_o out 1 pulse, frame_bank_o out 1, bank_release_i in 1, release_bank_i in 1 (engine frees bank).
REQ-008 SHALL have ports: err_o out 1 (OR of err_code_o), err_code_o out 3 sticky {cfg,long,short}, err_clr_i in 1, frame_cnt_o out 16.

Function
REQ-009 SHALL implement FSM states IDLE, FILL, WAIT_BANK.
REQ-010 IDLE: s_ready_o=0; when enable_i=1 and cfg valid (3 <= cfg_log2_len_i <= MAX_LOG2) SHALL latch cfg, clear sample count, go FILL.
REQ-011 IDLE with enable_i=1 and invalid cfg SHALL set err_code_o[2] and remain IDLE.
REQ-012 FILL: s_ready_o=1 whenever fill bank is free; sample accepted on s_valid_i&&s_ready_o.
REQ-013 Each accepted sample SHALL produce mem_we_o=1 exactly one cycle later with mem_wdata_o=sample and mem_bank_o=fill bank.
REQ-014 mem_addr_o SHALL be count (cfg_bitrev_i=0) or count bit-reversed over latched log2 length (cfg_bitrev_i=1), upper bits zero.
REQ-015 Count SHALL increment per accepted sample and wrap to 0 after N-1, N=2^latched length.
REQ-016 On accept of sample N-1: bank marked full, fill bank toggles, frame_ready_o=1 for one cycle two cycles after that handshake (after final write), frame_bank_o=completed bank, frame_cnt_o increments (wraps at 65535->0).
REQ-017 s_last_i=1 with count<N-1 SHALL set err_code_o[0], discard frame (bank stays free, no frame_ready_o), reset count to 0.
REQ-018 Sample N-1 without s_last_i SHALL set err_code_o[1]; frame still completes normally.
REQ-019 After completion, if new fill bank is full SHALL go WAIT_BANK with s_ready_o=0; leave to FILL the cycle after that bank is released.
REQ-020 bank_release_i SHALL clear full flag of bank release_bank_i; release of a free bank ignored.
REQ-021 Release and completion in same cycle SHALL apply release first (no WAIT_BANK entry if released bank is next).
REQ-022 enable_i=0 SHALL take effect only at a frame boundary (count=0); then go IDLE, full flags retained.
REQ-023 err_clr_i SHALL clear err_code_o next cycle; simultaneous new error wins (bit set).
REQ-024 cfg changes outside IDLE SHALL be ignored.

Reset
REQ-025 reset_n_i low SHALL asynchronously force IDLE, count=0, fill bank 0, both banks free, and all outputs 0 (s_ready_o, mem_*, frame_ready_o, frame_bank_o, err_*, frame_cnt_o).
REQ-026 Reset mid-frame SHALL discard partial frame with no frame_ready_o; pending write pipeline stage dropped.

Structure
REQ-027 Shared fft_pkg SHALL hold loader state enum, error-bit index constants, and MAX_LOG2 default.
REQ-028 Bit reversal SHALL be one sub-module fft_bitrev (combinational, variable length), reusable by output stage.

Verification
REQ-029 log2=3, bitrev=1, 8 samples 0..7 with last on 7 -> writes at addr 0,4,2,6,1,5,3,7 bank 0; frame_ready_o pulse, frame_bank_o=0, frame_cnt_o=1.
REQ-030 log2=3, two frames no release -> second frame to bank 1, then s_ready_o=0 in WAIT_BANK; release bank 0 -> s_ready_o=1 next cycle.
REQ-031 log2=4, s_last_i on sample 5 -> err_code_o=3'b001, no frame_ready_o, next 16 samples complete a frame in bank 0.
REQ-032 cfg_log2_len_i=2 or 11 with MAX_LOG2=10 -> err_code_o=3'b100, s_ready_o stays 0; err_clr_i -> 0.
REQ-033 Assert reset_n_i low after 5 of 8 samples -> all outputs 0 immediately; post-reset frame lands in bank 0 from addr 0.
REQ-034 Random s_valid_i gaps, log2=10 -> 1024 writes, each address exactly once, frame_ready_o once.
